rib_arbiter: RTL and testbench



---
 rtl/rib_arbiter.sv | 82 ++++++++
 tb/tb_rib_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rib_arbiter.sv
// rib_arbiter: registered 4-master RIB bus arbiter with lock, lock limit and optional round-robin.
// Define RIB_ARB_RR_EN for round-robin selection; otherwise fixed priority m3 > m2 > m0 > m1.
module rib_arbiter #(
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_i,
    input  logic [3:0]       lock_i,
    output logic [3:0]       grant_o,
    output logic [1:0]       grant_id_o,
    output logic             grant_vld_o,
    output logic             hold_flag_o,
    output logic [CNT_W-1:0] lock_cnt_o
);
    typedef enum logic {IDLE, OWNED} state_t;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LOCK);
    state_t state_q, state_d;
    logic [1:0] owner_q, owner_d, win;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic keep, others;
`ifdef RIB_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    always_comb begin
        win = '0;
        for (int k = 3; k >= 0; k--)
            if (req_i[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
`else
    assign win = req_i[3] ? 2'd3 : req_i[2] ? 2'd2 : req_i[0] ? 2'd0 : 2'd1;
`endif
    assign others = |(req_i & ~(4'b0001 << owner_q));
    assign keep = state_q == OWNED && req_i[owner_q] && lock_i[owner_q] && (cnt_q < MAX_C || !others);
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
`ifdef RIB_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (keep) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else if (req_i == 4'b0000) begin
            state_d = IDLE;
            owner_d = 2'd0;
            cnt_d   = '0;
        end else begin
            // every arbitration win starts a fresh lock window, even if the owner re-wins
            state_d = OWNED;
            owner_d = win;
            cnt_d   = '0;
`ifdef RIB_ARB_RR_EN
            ptr_d   = win + 2'd1;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            cnt_q       <= '0;
            grant_o     <= 4'b0000;
            hold_flag_o <= 1'b0;
`ifdef RIB_ARB_RR_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            grant_o     <= state_d == OWNED ? 4'b0001 << owner_d : 4'b0000;
            hold_flag_o <= state_d == OWNED && owner_d != 2'd1;
`ifdef RIB_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end
    assign grant_id_o  = owner_q;
    assign grant_vld_o = state_q == OWNED;
    assign lock_cnt_o  = cnt_q;
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed test-plan scenarios plus randomized traffic checked against a behavioural model.
module tb_rib_arbiter;
    localparam int MAX_LOCK = 16;
    localparam int CNT_W = 5;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_i, lock_i, grant_o;
    logic [1:0] grant_id_o;
    logic grant_vld_o, hold_flag_o;
    logic [CNT_W-1:0] lock_cnt_o;
    int total = 0;
    int bad = 0;
    int m_owner = -1;
    int m_cnt = 0;
    int m_ptr = 0;

    rib_arbiter #(.MAX_LOCK(MAX_LOCK), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .grant_o(grant_o),
        .grant_id_o(grant_id_o), .grant_vld_o(grant_vld_o), .hold_flag_o(hold_flag_o),
        .lock_cnt_o(lock_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int others_req(input logic [3:0] r, input int o);
        int n = 0;
        for (int i = 0; i < 4; i++) if (r[i] && i != o) n++;
        return n;
    endfunction

    task automatic model_edge();
        int order[4] = '{3, 2, 0, 1};
        int w = -1;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0;
        end else if (m_owner >= 0 && req_i[m_owner] && lock_i[m_owner] &&
                     (m_cnt < MAX_LOCK || others_req(req_i, m_owner) == 0)) begin
            m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
        end else if (req_i == 4'b0000) begin
            m_owner = -1; m_cnt = 0;
        end else begin
`ifdef RIB_ARB_RR_EN
            for (int k = 0; k < 4; k++) if (w < 0 && req_i[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
`else
            for (int k = 0; k < 4; k++) if (w < 0 && req_i[order[k]]) w = order[k];
`endif
            m_owner = w; m_cnt = 0; m_ptr = (w + 1) % 4;
        end
    endtask

    task automatic compare_all();
        chk("grant_o", int'(grant_o), m_owner >= 0 ? (1 << m_owner) : 0);
        chk("grant_id_o", int'(grant_id_o), m_owner >= 0 ? m_owner : 0);
        chk("grant_vld_o", int'(grant_vld_o), m_owner >= 0 ? 1 : 0);
        chk("hold_flag_o", int'(hold_flag_o), (m_owner >= 0 && m_owner != 1) ? 1 : 0);
        chk("lock_cnt_o", int'(lock_cnt_o), m_cnt);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rs);
        rst = rs; req_i = r; lock_i = l;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] r = 4'b0000;
        logic [3:0] l = 4'b0000;
        step(4'b0000, 4'b0000, 1'b1);
        chk("reset_grant", int'(grant_o), 0);
        chk("reset_cnt", int'(lock_cnt_o), 0);
        step(4'b0010, 4'b0000, 1'b0);
        chk("m1_grant", int'(grant_o), 2);
        chk("m1_hold", int'(hold_flag_o), 0);

        step(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b0000, 1'b0);
`ifdef RIB_ARB_RR_EN
            chk("rr_seq", int'(grant_id_o), i);
`else
            chk("fixed_seq", int'(grant_id_o), 3);
`endif
        end

        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0100, 4'b0100, 1'b0);
        for (int i = 0; i < MAX_LOCK; i++) begin
            step(4'b0110, 4'b0100, 1'b0);
            chk("lock_keep_id", int'(grant_id_o), 2);
        end
        chk("lock_cnt_max", int'(lock_cnt_o), MAX_LOCK);
        step(4'b0110, 4'b0100, 1'b0);
`ifdef RIB_ARB_RR_EN
        chk("lock_limit_id", int'(grant_id_o), 1);
`else
        chk("lock_limit_id", int'(grant_id_o), 2);
`endif
        chk("lock_limit_cnt", int'(lock_cnt_o), 0);

        step(4'b0001, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        chk("handoff_grant", int'(grant_o), 8);
        chk("handoff_hold", int'(hold_flag_o), 1);

        step(4'b1000, 4'b1000, 1'b0);
        step(4'b1000, 4'b1000, 1'b1);
        chk("rst_mid_grant", int'(grant_o), 0);
        chk("rst_mid_vld", int'(grant_vld_o), 0);
        step(4'b0010, 4'b0000, 1'b0);
        chk("post_rst_id", int'(grant_id_o), 1);

        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b1111, 1'b0);
            chk("idle_vld", int'(grant_vld_o), 0);
            chk("idle_hold", int'(hold_flag_o), 0);
        end

        step(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 40; i++) step(4'b0001, 4'b0001, 1'b0);
        chk("saturate_cnt", int'(lock_cnt_o), (1 << CNT_W) - 1);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            if ($urandom_range(7) == 0) l = 4'($urandom);
            step(r, l, $urandom_range(99) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
